// File: rtl/svi_chan_pkg.sv
// Shared types, default sizes and the keyed-sum helper for the SVI channel override block.
package svi_chan_pkg;

    localparam int SVI_W     = 8;
    localparam int SVI_N     = 4;
    localparam int SVI_CNT_W = 8;
    localparam logic [SVI_W-1:0] SVI_KEY = 8'h04;

    typedef logic [SVI_W-1:0]     data_t;
    typedef logic [SVI_CNT_W-1:0] cnt_t;

    // 32-bit container so any W up to 32 can share it; callers truncate to W, which drops the carry.
    function automatic logic [31:0] key_sum(input logic [31:0] z, input logic [31:0] y,
                                            input logic [31:0] key);
        return (z ^ key) + (y ^ key);
    endfunction

endpackage

// File: rtl/I_chan.sv
// SVI operand bundle: one (z,y) pair per channel. P1 is the consumer view, P2 the producer view.
interface I_chan #(
    parameter int W = 8,
    parameter int N = 4
);
    logic [N-1:0][W-1:0] z;
    logic [N-1:0][W-1:0] y;

    modport P1 (input  z, input  y);
    modport P2 (output z, output y);
endinterface

// File: rtl/svi_ovr_timer.sv
// Per-channel override slot: load/decrement timer plus held value.
// SVI_OVR_XPROP_EN adds a latched X-request bit that turns the value into all-X while active.
module svi_ovr_timer #(
    parameter int W     = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             we,
    input  logic [CNT_W-1:0] len,
    input  logic [W-1:0]     data,
    input  logic             x,
    output logic             active,
    output logic [W-1:0]     value
);
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     ovr_q;

    // A write wins over the decrement, so a reload restarts the full length.
    always_ff @(posedge clk) begin
        if (srst) begin
            cnt_q <= '0;
            ovr_q <= '0;
        end else if (we) begin
            cnt_q <= len;
            ovr_q <= data;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign active = (cnt_q != '0);

`ifdef SVI_OVR_XPROP_EN
    logic x_q;

    always_ff @(posedge clk) begin
        if (srst)    x_q <= 1'b0;
        else if (we) x_q <= x;
    end

    assign value = x_q ? {W{1'bx}} : ovr_q;
`else
    logic unused_x;
    assign unused_x = x;
    assign value    = ovr_q;
`endif

endmodule

// File: rtl/svi_chan_override.sv
// N-channel keyed adder with one-entry output registers and a timed per-channel output override.
// Optional SVI_OVR_XPROP_EN lets an override drive X on its channel.
module svi_chan_override
    import svi_chan_pkg::*;
#(
    parameter int W     = SVI_W,
    parameter int N     = SVI_N,
    parameter int CNT_W = SVI_CNT_W,
    parameter logic [W-1:0] KEY = W'(SVI_KEY),
    localparam int CH_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             i_clk,
    input  logic             i_srst,
    I_chan.P1                u_I,
    input  logic [N-1:0]     i_valid,
    output logic [N-1:0]     o_ready,
    output logic [N-1:0]     o_valid,
    input  logic [N-1:0]     i_ready,
    output logic [N*W-1:0]   o_data,
    input  logic             i_ovr_we,
    input  logic [CH_W-1:0]  i_ovr_ch,
    input  logic [W-1:0]     i_ovr_data,
    input  logic [CNT_W-1:0] i_ovr_len,
    input  logic             i_ovr_x,
    output logic [N-1:0]     o_ovr_active
);

    for (genvar c = 0; c < N; c++) begin : g_ch
        logic [W-1:0] data_q;
        logic [W-1:0] sum;
        logic [W-1:0] ovr_val;
        logic         valid_q;
        logic         act;
        logic         ovr_we;

        assign sum        = W'(key_sum(32'(u_I.z[c]), 32'(u_I.y[c]), 32'(KEY)));
        assign o_ready[c] = !valid_q || i_ready[c];

        always_ff @(posedge i_clk) begin
            if (i_srst) begin
                valid_q <= 1'b0;
                data_q  <= '0;
            end else if (o_ready[c]) begin
                valid_q <= i_valid[c];
                if (i_valid[c]) data_q <= sum;
            end
        end

        // Channel numbers >= N never match, so out-of-range writes fall on the floor.
        assign ovr_we = i_ovr_we && (i_ovr_ch == CH_W'(c));

        svi_ovr_timer #(.W(W), .CNT_W(CNT_W)) u_tmr (
            .clk    (i_clk),
            .srst   (i_srst),
            .we     (ovr_we),
            .len    (i_ovr_len),
            .data   (i_ovr_data),
            .x      (i_ovr_x),
            .active (act),
            .value  (ovr_val)
        );

        // Override only masks the data; the handshake keeps running underneath.
        assign o_valid[c]        = valid_q;
        assign o_ovr_active[c]   = act;
        assign o_data[c*W +: W]  = act ? ovr_val : data_q;
    end

endmodule

// File: tb/tb_svi_chan_override.sv
// Directed bench for svi_chan_override: W=8, N=4, KEY=8'h04.
module tb_svi_chan_override;

    logic        i_clk = 1'b0;
    logic        i_srst;
    logic [3:0]  i_valid, o_ready, o_valid, i_ready, o_ovr_active;
    logic [31:0] o_data;
    logic        i_ovr_we, i_ovr_x;
    logic [1:0]  i_ovr_ch;
    logic [7:0]  i_ovr_data, i_ovr_len;

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    I_chan #(.W(8), .N(4)) u_if ();

    svi_chan_override dut (
        .i_clk        (i_clk),
        .i_srst       (i_srst),
        .u_I          (u_if),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .i_ovr_we     (i_ovr_we),
        .i_ovr_ch     (i_ovr_ch),
        .i_ovr_data   (i_ovr_data),
        .i_ovr_len    (i_ovr_len),
        .i_ovr_x      (i_ovr_x),
        .o_ovr_active (o_ovr_active)
    );

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic ovr_write(input logic [1:0] ch, input logic [7:0] data, input logic [7:0] len,
                             input logic x);
        i_ovr_we = 1'b1; i_ovr_ch = ch; i_ovr_data = data; i_ovr_len = len; i_ovr_x = x;
        tick();
        i_ovr_we = 1'b0; i_ovr_x = 1'b0;
    endtask

    task automatic test_reset;
        i_srst = 1'b1;
        repeat (3) begin
            i_valid = 4'($urandom); i_ready = 4'($urandom);
            u_if.z = $urandom; u_if.y = $urandom;
            i_ovr_we = 1'b1; i_ovr_ch = 2'($urandom);
            i_ovr_len = 8'($urandom) | 8'h01; i_ovr_data = 8'($urandom); i_ovr_x = 1'b0;
            tick();
        end
        n_cmp++; if (o_valid !== 4'h0) begin n_err++; $display("FAIL rst_valid: got %h want 0", o_valid); end
        n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", o_data); end
        n_cmp++; if (o_ovr_active !== 4'h0) begin n_err++; $display("FAIL rst_active: got %h want 0", o_ovr_active); end
        i_srst = 1'b0; i_valid = 4'h0; i_ready = 4'hF; i_ovr_we = 1'b0;
        #1;
        n_cmp++; if (o_ready !== 4'hF) begin n_err++; $display("FAIL rst_ready: got %h want f", o_ready); end
        tick();
        n_cmp++; if (o_ovr_active !== 4'h0) begin n_err++; $display("FAIL rst_we_drop: got %h want 0", o_ovr_active); end
    endtask

    task automatic test_datapath;
        u_if.z[0] = 8'h10; u_if.y[0] = 8'h20; i_valid = 4'b0001;
        tick();
        i_valid = 4'h0;
        n_cmp++; if (o_valid[0] !== 1'b1) begin n_err++; $display("FAIL dp_valid: got %b want 1", o_valid[0]); end
        n_cmp++; if (o_data[7:0] !== 8'h38) begin n_err++; $display("FAIL dp_sum: got %h want 38", o_data[7:0]); end
        u_if.z[0] = 8'hFF; u_if.y[0] = 8'hFF; i_valid = 4'b0001;
        tick();
        i_valid = 4'h0;
        n_cmp++; if (o_data[7:0] !== 8'hF6) begin n_err++; $display("FAIL dp_wrap: got %h want f6", o_data[7:0]); end
        tick();
        n_cmp++; if (o_valid[0] !== 1'b0) begin n_err++; $display("FAIL dp_drain: got %b want 0", o_valid[0]); end
        n_cmp++; if (o_data[7:0] !== 8'hF6) begin n_err++; $display("FAIL dp_hold: got %h want f6", o_data[7:0]); end
        // all four channels at once
        u_if.z = {8'h30, 8'h20, 8'h10, 8'h00}; u_if.y = {8'h03, 8'h02, 8'h01, 8'h00}; i_valid = 4'hF;
        tick();
        i_valid = 4'h0;
        n_cmp++; if (o_valid !== 4'hF) begin n_err++; $display("FAIL dp_all_valid: got %h want f", o_valid); end
        n_cmp++; if (o_data !== 32'h3B2A1908) begin n_err++; $display("FAIL dp_all_data: got %h want 3b2a1908", o_data); end
        tick();
    endtask

    task automatic test_backpressure;
        i_ready = 4'b1101;
        u_if.z[1] = 8'h01; u_if.y[1] = 8'h02; i_valid = 4'b0010;
        tick();
        u_if.z[1] = 8'h33; u_if.y[1] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (o_data[15:8] !== 8'h0B) begin n_err++; $display("FAIL bp_data[%0d]: got %h want 0b", i, o_data[15:8]); end
            n_cmp++; if (o_valid[1] !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", i, o_valid[1]); end
            n_cmp++; if (o_ready[1] !== 1'b0) begin n_err++; $display("FAIL bp_ready[%0d]: got %b want 0", i, o_ready[1]); end
            tick();
        end
        i_valid = 4'h0; i_ready = 4'hF;
        #1;
        n_cmp++; if (o_ready[1] !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", o_ready[1]); end
        tick();
        n_cmp++; if (o_valid[1] !== 1'b0) begin n_err++; $display("FAIL bp_no_dup: got %b want 0", o_valid[1]); end
        n_cmp++; if (o_data[15:8] !== 8'h0B) begin n_err++; $display("FAIL bp_no_overwrite: got %h want 0b", o_data[15:8]); end
    endtask

    task automatic test_override;
        // park 8'h08 on ch2 and hold it there so the override sits over a live valid
        i_ready = 4'b1011; u_if.z[2] = 8'h00; u_if.y[2] = 8'h00; i_valid = 4'b0100;
        tick();
        i_valid = 4'h0;
        ovr_write(2'd2, 8'hA5, 8'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (o_ovr_active !== 4'b0100) begin n_err++; $display("FAIL ovr_active[%0d]: got %h want 4", i, o_ovr_active); end
            n_cmp++; if (o_data[23:16] !== 8'hA5) begin n_err++; $display("FAIL ovr_data[%0d]: got %h want a5", i, o_data[23:16]); end
            tick();
        end
        n_cmp++; if (o_ovr_active[2] !== 1'b0) begin n_err++; $display("FAIL ovr_expire: got %b want 0", o_ovr_active[2]); end
        n_cmp++; if (o_data[23:16] !== 8'h08) begin n_err++; $display("FAIL ovr_revert: got %h want 08", o_data[23:16]); end
        n_cmp++; if (o_valid[2] !== 1'b1) begin n_err++; $display("FAIL ovr_valid_kept: got %b want 1", o_valid[2]); end
        // reload during cycle 2 of a 3-cycle override
        ovr_write(2'd2, 8'hA5, 8'd3, 1'b0);
        tick();
        n_cmp++; if (o_ovr_active[2] !== 1'b1) begin n_err++; $display("FAIL rl_pre: got %b want 1", o_ovr_active[2]); end
        ovr_write(2'd2, 8'h5A, 8'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            n_cmp++; if (o_ovr_active[2] !== 1'b1) begin n_err++; $display("FAIL rl_active[%0d]: got %b want 1", i, o_ovr_active[2]); end
            n_cmp++; if (o_data[23:16] !== 8'h5A) begin n_err++; $display("FAIL rl_data[%0d]: got %h want 5a", i, o_data[23:16]); end
            tick();
        end
        n_cmp++; if (o_ovr_active[2] !== 1'b0) begin n_err++; $display("FAIL rl_expire: got %b want 0", o_ovr_active[2]); end
        // cancel with len=0
        ovr_write(2'd2, 8'h11, 8'd10, 1'b0);
        n_cmp++; if (o_ovr_active[2] !== 1'b1) begin n_err++; $display("FAIL cx_active: got %b want 1", o_ovr_active[2]); end
        ovr_write(2'd2, 8'h11, 8'd0, 1'b0);
        n_cmp++; if (o_ovr_active[2] !== 1'b0) begin n_err++; $display("FAIL cx_cancel: got %b want 0", o_ovr_active[2]); end
        n_cmp++; if (o_data[23:16] !== 8'h08) begin n_err++; $display("FAIL cx_data: got %h want 08", o_data[23:16]); end
        i_ready = 4'hF;
        tick();
    endtask

    task automatic test_reset_mid_override;
        ovr_write(2'd3, 8'h77, 8'd100, 1'b0);
        tick();
        n_cmp++; if (o_data[31:24] !== 8'h77) begin n_err++; $display("FAIL mr_pre: got %h want 77", o_data[31:24]); end
        i_srst = 1'b1;
        ovr_write(2'd3, 8'h11, 8'd50, 1'b0);
        i_srst = 1'b0;
        n_cmp++; if (o_ovr_active !== 4'h0) begin n_err++; $display("FAIL mr_active: got %h want 0", o_ovr_active); end
        n_cmp++; if (o_data !== 32'h0) begin n_err++; $display("FAIL mr_data: got %h want 0", o_data); end
        tick();
        n_cmp++; if (o_ovr_active !== 4'h0) begin n_err++; $display("FAIL mr_we_drop: got %h want 0", o_ovr_active); end
    endtask

    task automatic test_xprop;
        ovr_write(2'd1, 8'hC3, 8'd2, 1'b1);
        for (int i = 0; i < 2; i++) begin
`ifdef SVI_OVR_XPROP_EN
            n_cmp++; if (o_data[15:8] !== 8'bx) begin n_err++; $display("FAIL xp_x[%0d]: got %h want x", i, o_data[15:8]); end
`else
            n_cmp++; if (o_data[15:8] !== 8'hC3) begin n_err++; $display("FAIL xp_val[%0d]: got %h want c3", i, o_data[15:8]); end
`endif
            tick();
        end
        n_cmp++; if (o_data[15:8] !== 8'h00) begin n_err++; $display("FAIL xp_expire: got %h want 00", o_data[15:8]); end
    endtask

    initial begin
        i_srst = 1'b0; i_valid = '0; i_ready = '0; i_ovr_we = 1'b0; i_ovr_x = 1'b0;
        i_ovr_ch = '0; i_ovr_data = '0; i_ovr_len = '0; u_if.z = '0; u_if.y = '0;
        tick();
        test_reset();
        test_datapath();
        test_backpressure();
        test_override();
        test_reset_mid_override();
        test_xprop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
